// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory controller:
// FSM states, jdo field positions and status-register bit positions.
package cpu_debug_ocimem_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_J_RD   = 3'd1,
        S_J_RD_W = 3'd2,
        S_J_WR   = 3'd3,
        S_A_RD   = 3'd4,
        S_A_RD_W = 3'd5,
        S_A_DONE = 3'd6
    } ocimem_state_t;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LOAD = 35;
    localparam int JDO_RD_REQ    = 34;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;

    localparam int STAT_PRESENT  = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_OVERRUN  = 2;

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port debug monitor RAM with byte enables and a registered read port.
// Read data appears on q_o the cycle after a read and holds until the next read.
module cpu_debug_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     q_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end else begin
                q_q <= mem_q[addr_i];
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug monitor RAM controller: serves decoded JTAG commands and the CPU's Avalon
// debug-memory slave. Optional macro OCIMEM_AUTOINC_EN: post-increment MonAReg after JTAG accesses.
module cpu_debug_ocimem_ctrl
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W:0]   address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [3:0]        byteenable,
    input  logic [31:0]       writedata,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy
);

    ocimem_state_t     state_q;
    logic [ADDR_W-1:0] mon_addr_q;
    logic [DATA_W-1:0] mon_data_q, cmd_wdata_q, readdata_q, av_wdata_q;
    logic              pend_q, pend_wr_q, overrun_q, waitrequest_q;
    logic [ADDR_W:0]   av_addr_q;
    logic [3:0]        av_be_q;
    logic              av_write_q, av_dbg_q;

    logic addr_load, rd_cmd, wr_cmd, new_cmd, av_req, direct_go, av_is_stat;
    logic              ram_en, ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_q, status_word;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = &{1'b0, jdo[37:36], jdo[2:0]};

    assign addr_load = take_action_ocimem_a & jdo[JDO_ADDR_LOAD];
    assign rd_cmd    = (addr_load & jdo[JDO_RD_REQ]) | take_no_action_ocimem_a;
    assign wr_cmd    = take_action_ocimem_b;
    assign new_cmd   = rd_cmd | wr_cmd;
    assign av_req    = chipselect & (read | write);
    // An idle FSM with no competing Avalon request starts the JTAG command at once.
    assign direct_go = (state_q == S_IDLE) & ~pend_q & ~av_req;
    assign av_is_stat = av_addr_q[ADDR_W];

    assign jtag_busy = pend_q | (state_q == S_J_RD) | (state_q == S_J_RD_W) | (state_q == S_J_WR);

    always_comb begin
        status_word                = '0;
        status_word[STAT_PRESENT]  = 1'b1;
        status_word[STAT_BUSY]     = jtag_busy;
        status_word[STAT_OVERRUN]  = overrun_q;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_addr  = mon_addr_q;
        ram_wdata = cmd_wdata_q;
        case (state_q)
            S_J_RD: ram_en = 1'b1;
            S_J_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            S_A_RD: begin
                ram_en   = ~av_is_stat;
                ram_addr = av_addr_q[ADDR_W-1:0];
            end
            S_A_DONE: begin
                ram_en    = av_write_q & av_dbg_q & ~av_is_stat;
                ram_we    = 1'b1;
                ram_be    = av_be_q;
                ram_addr  = av_addr_q[ADDR_W-1:0];
                ram_wdata = av_wdata_q;
            end
            default: ;
        endcase
    end

    cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mon_addr_q    <= '0;
            mon_data_q    <= '0;
            cmd_wdata_q   <= '0;
            readdata_q    <= '0;
            av_wdata_q    <= '0;
            pend_q        <= 1'b0;
            pend_wr_q     <= 1'b0;
            overrun_q     <= 1'b0;
            waitrequest_q <= 1'b1;
            av_addr_q     <= '0;
            av_be_q       <= '0;
            av_write_q    <= 1'b0;
            av_dbg_q      <= 1'b0;
        end else begin
            waitrequest_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= pend_wr_q ? S_J_WR : S_J_RD;
                    end else if (av_req) begin
                        av_addr_q     <= address;
                        av_wdata_q    <= writedata;
                        av_be_q       <= byteenable;
                        av_write_q    <= ~read;
                        av_dbg_q      <= debugaccess;
                        state_q       <= read ? S_A_RD : S_A_DONE;
                        waitrequest_q <= read;
                    end else if (new_cmd) begin
                        state_q <= wr_cmd ? S_J_WR : S_J_RD;
                    end
                end
                S_J_RD:   state_q <= S_J_RD_W;
                S_J_RD_W: begin
                    mon_data_q <= ram_q;
`ifdef OCIMEM_AUTOINC_EN
                    mon_addr_q <= mon_addr_q + ADDR_W'(1);
`endif
                    state_q    <= S_IDLE;
                end
                S_J_WR: begin
`ifdef OCIMEM_AUTOINC_EN
                    mon_addr_q <= mon_addr_q + ADDR_W'(1);
`endif
                    state_q    <= S_IDLE;
                end
                S_A_RD:   state_q <= S_A_RD_W;
                S_A_RD_W: begin
                    readdata_q    <= av_is_stat ? status_word : ram_q;
                    waitrequest_q <= 1'b0;
                    state_q       <= S_A_DONE;
                end
                S_A_DONE: begin
                    if (av_write_q && av_is_stat && av_wdata_q[1]) overrun_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default:  state_q <= S_IDLE;
            endcase

            // Strobe effects are applied last so a newer JTAG command wins over completing work.
            if (addr_load) mon_addr_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (new_cmd) begin
                if (pend_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    if (wr_cmd) begin
                        mon_data_q  <= jdo[JDO_WDATA_LSB +: DATA_W];
                        cmd_wdata_q <= jdo[JDO_WDATA_LSB +: DATA_W];
                    end
                    if (!direct_go) begin
                        pend_q    <= 1'b1;
                        pend_wr_q <= wr_cmd;
                    end
                end
            end
        end
    end

    assign readdata    = readdata_q;
    assign waitrequest = waitrequest_q;
    assign MonDReg     = mon_data_q;

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Directed bench for cpu_debug_ocimem_ctrl: JTAG and Avalon access paths,
// collision ordering, overrun flag, reset abort and address wrap.
module tb_cpu_debug_ocimem_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [AW:0]   address;
  logic          chipselect, read, write, debugaccess;
  logic [3:0]    byteenable;
  logic [31:0]   writedata, readdata, MonDReg;
  logic          waitrequest, jtag_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;
  int lat, n;

  cpu_debug_ocimem_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg), .jtag_busy(jtag_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rdreq);
    logic [37:0] j;
    j = '0;
    j[35] = 1'b1;
    j[34] = rdreq;
    j[17 +: 8] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
  task automatic jtag_pulse(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (jtag_busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic jtag_write_at(input logic [7:0] a, input logic [31:0] d);
    int c;
    jtag_pulse(0, jdo_addr(a, 1'b0));
    jtag_pulse(2, jdo_data(d));
    wait_idle(c);
  endtask

  task automatic jtag_read_at(input logic [7:0] a, output logic [31:0] d);
    int c;
    jtag_pulse(0, jdo_addr(a, 1'b1));
    wait_idle(c);
    d = MonDReg;
  endtask

  // nstb: number of leading request cycles that also carry take_no_action_ocimem_a.
  task automatic av_access(input logic is_wr, input logic [AW:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic dbg, input int nstb,
                           output logic [31:0] data, output int cyc);
    @(negedge clk);
    chipselect = 1'b1; read = ~is_wr; write = is_wr; address = a;
    writedata = wd; byteenable = be; debugaccess = dbg;
    take_no_action_ocimem_a = (nstb >= 1);
    cyc = 1;
    while (waitrequest && cyc < 50) begin
      @(negedge clk);
      cyc++;
      take_no_action_ocimem_a = (nstb >= cyc);
    end
    data = readdata;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    byteenable = 4'h0; writedata = '0; debugaccess = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wait", {31'b0, waitrequest}, 32'h1);
    check("rst_mond", MonDReg, 32'h0);
    check("rst_busy", {31'b0, jtag_busy}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;

    av_access(1'b0, 9'h100, 32'h0, 4'hF, 1'b0, 0, rd, lat);
    check("stat0_lat", lat, 4);
    check("stat0", rd, 32'h1);

    // JTAG write then read back, with MonDReg timing
    jtag_pulse(0, jdo_addr(8'h10, 1'b0));
    jtag_pulse(2, jdo_data(32'hDEADBEEF));
    check("jwr_mond", MonDReg, 32'hDEADBEEF);
    check("jwr_busy", {31'b0, jtag_busy}, 32'h1);
    wait_idle(n);
    jtag_write_at(8'h20, 32'h11111111);
    check("jwr2_mond", MonDReg, 32'h11111111);
    jtag_pulse(0, jdo_addr(8'h10, 1'b1));
    check("jrd_c1_mond", MonDReg, 32'h11111111);
    check("jrd_c1_busy", {31'b0, jtag_busy}, 32'h1);
    @(negedge clk);
    check("jrd_c2_busy", {31'b0, jtag_busy}, 32'h1);
    @(negedge clk);
    check("jrd_mond", MonDReg, 32'hDEADBEEF);
    check("jrd_busy", {31'b0, jtag_busy}, 32'h0);

    av_access(1'b0, 9'h010, 32'h0, 4'hF, 1'b1, 0, rd, lat);
    check("av_rd_jtag", rd, 32'hDEADBEEF);

    // Avalon byte-enable write and debugaccess gating
    av_access(1'b1, 9'h005, 32'hFFFFFFFF, 4'hF, 1'b1, 0, rd, lat);
    check("av_wr_lat", lat, 2);
    av_access(1'b1, 9'h005, 32'h12345678, 4'b0011, 1'b1, 0, rd, lat);
    av_access(1'b0, 9'h005, 32'h0, 4'hF, 1'b1, 0, rd, lat);
    check("av_rd_lat", lat, 4);
    check("av_rd_be", rd, 32'hFFFF5678);
    av_access(1'b1, 9'h005, 32'h00000000, 4'hF, 1'b0, 0, rd, lat);
    av_access(1'b0, 9'h005, 32'h0, 4'hF, 1'b1, 0, rd, lat);
    check("av_nodbg", rd, 32'hFFFF5678);

    // Collision: Avalon read and JTAG read strobe in the same cycle
    jtag_write_at(8'h30, 32'h22222222);
    jtag_pulse(0, jdo_addr(8'h10, 1'b0));
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 9'h005; debugaccess = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    lat = 1;
    while (waitrequest && lat < 50) begin
      @(negedge clk);
      lat++;
      take_no_action_ocimem_a = 1'b0;
    end
    check("col_lat", lat, 4);
    check("col_rdata", readdata, 32'hFFFF5678);
    check("col_mond_hold", MonDReg, 32'h22222222);
    check("col_busy", {31'b0, jtag_busy}, 32'h1);
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    wait_idle(n);
    check("col_jtag_lat", n, 3);
    check("col_mond", MonDReg, 32'hDEADBEEF);

    // Overrun: second strobe while the first is still pending
    av_access(1'b1, 9'h006, 32'hCAFE0000, 4'hF, 1'b1, 2, rd, lat);
    wait_idle(n);
    av_access(1'b0, 9'h100, 32'h0, 4'hF, 1'b0, 0, rd, lat);
    check("ovr_set", rd, 32'h5);
    av_access(1'b1, 9'h100, 32'h2, 4'hF, 1'b0, 0, rd, lat);
    av_access(1'b0, 9'h100, 32'h0, 4'hF, 1'b0, 0, rd, lat);
    check("ovr_clr", rd, 32'h1);
    av_access(1'b0, 9'h006, 32'h0, 4'hF, 1'b1, 0, rd, lat);
    check("ovr_wr_data", rd, 32'hCAFE0000);

    // Address wrap at the top of the RAM
    jtag_pulse(0, jdo_addr(8'hFF, 1'b0));
    jtag_pulse(2, jdo_data(32'hA));
    wait_idle(n);
    jtag_pulse(2, jdo_data(32'hB));
    wait_idle(n);
`ifdef OCIMEM_AUTOINC_EN
    jtag_read_at(8'hFF, rd);
    check("inc_ff", rd, 32'hA);
    jtag_read_at(8'h00, rd);
    check("inc_wrap", rd, 32'hB);
`else
    jtag_read_at(8'hFF, rd);
    check("noinc_ff", rd, 32'hB);
`endif

    // Reset in the middle of an Avalon read with a JTAG command pending
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 9'h005; debugaccess = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    check("pre_rst_wait", {31'b0, waitrequest}, 32'h1);
    check("pre_rst_busy", {31'b0, jtag_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wait", {31'b0, waitrequest}, 32'h1);
    check("mid_rst_mond", MonDReg, 32'h0);
    check("mid_rst_busy", {31'b0, jtag_busy}, 32'h0);
    check("mid_rst_rdata", readdata, 32'h0);
    chipselect = 1'b0; read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    av_access(1'b0, 9'h005, 32'h0, 4'hF, 1'b1, 0, rd, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_rd", rd, 32'hFFFF5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ocimem_ctrl.md
Name: cpu_debug_ocimem_ctrl

Overview:
Sysclk-domain consumer of the debug slave's decoded JTAG actions (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Owns the debug monitor RAM.
- Arbitrates that RAM between JTAG host accesses and the CPU's Avalon debug-memory slave port.
- Returns JTAG read data on MonDReg, which feeds back into the debug slave's tck-side shift register.

Parameters:
ADDR_W, 8, RAM word-address width (1..16); depth = 2**ADDR_W words.
DATA_W, 32, word width; fixed at 32, since jdo packing depends on it.

Ports:
clk  in  1  system clock; single clock domain.
reset_n  in  1  asynchronous active-low reset.
jdo  in  38  JTAG data from debug slave, stable while any strobe is high.
take_action_ocimem_a  in  1  1-cycle strobe: JTAG address load / read command.
take_no_action_ocimem_a  in  1  1-cycle strobe: JTAG read at current address.
take_action_ocimem_b  in  1  1-cycle strobe: JTAG write at current address.
address  in  ADDR_W+1  Avalon word address; MSB=1 selects the status register.
chipselect  in  1  Avalon select.
read  in  1  Avalon read.
write  in  1  Avalon write.
byteenable  in  4  Avalon byte enables.
writedata  in  32  Avalon write data.
debugaccess  in  1  high = CPU is in debug mode.
readdata  out  32  Avalon read data; valid when waitrequest is low with read asserted.
waitrequest  out  1  Avalon stall.
MonDReg  out  32  last JTAG read data, or last JTAG write data.
jtag_busy  out  1  JTAG command pending or executing.

Behaviour:
- Reset: all registers clear. MonDReg=0, readdata=0, waitrequest=1, jtag_busy=0, MonAReg=0, state=IDLE, overrun=0. RAM contents are not reset.
- JTAG decode:
  - take_action_ocimem_a with jdo[35]=1: MonAReg <= jdo[17 +: ADDR_W]. If jdo[34]=1, also queue a read.
  - take_no_action_ocimem_a: queue a read at MonAReg.
  - take_action_ocimem_b: queue a write of jdo[34:3] to MonAReg, all byte enables set; MonDReg <= jdo[34:3] immediately.
- Pending JTAG command: one-deep register; jtag_busy = pending OR state in {J_RD, J_RD_W, J_WR}. A strobe that arrives while pending is already set is dropped and sets sticky overrun.
- FSM states: IDLE, J_RD, J_RD_W, J_WR, A_RD, A_RD_W, A_DONE.
  - IDLE: pending JTAG command wins → J_RD or J_WR. Otherwise, chipselect & (read|write) → A_RD (read) or A_DONE (write).
  - J_RD: issue RAM read → J_RD_W.
  - J_RD_W: MonDReg <= RAM q → IDLE.
  - J_WR: RAM write → IDLE.
  - Avalon writes complete in A_DONE. RAM is written only when debugaccess=1; otherwise the write is silently dropped.
  - Writes to the status register clear overrun when writedata[1]=1.
  - A_RD: RAM read (or status mux) → A_RD_W.
  - A_RD_W: readdata <= data → A_DONE.
  - A_DONE: waitrequest=0 for exactly 1 cycle → IDLE.
- Avalon latency: write = 2 cycles; read = 4 cycles, request to waitrequest low. Add +3 cycles if a JTAG command is in progress; JTAG always has priority at IDLE.
- waitrequest is low only in A_DONE. An Avalon master that drops chipselect mid-access: the FSM still completes the access.
- Status register (address MSB=1): {29'b0, overrun, jtag_busy, 1'b1 (present)}. Status reads ignore debugaccess.
- Same-cycle JTAG strobe and Avalon request in IDLE: the strobe is captured into pending this cycle. The Avalon request is accepted this cycle and the FSM moves to A_RD / A_DONE. JTAG is served next, at IDLE.
- Address wrap: MonAReg increments modulo 2**ADDR_W.
- Asynchronous reset mid-operation aborts any in-flight access; a partial write is not guaranteed.

Optional Feature:
OCIMEM_AUTOINC_EN
- Defined: MonAReg increments by 1 after every completed J_RD_W or J_WR, wrapping at 2**ADDR_W-1 → 0.
- Undefined: MonAReg changes only on an address load; the increment logic is absent.

Decomposition:
- Package cpu_debug_ocimem_pkg holds:
  - the FSM state enum;
  - JDO bit-position constants (JDO_ADDR_LOAD=35, JDO_RD_REQ=34, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3);
  - the status-register bit constants.
- Sub-module cpu_debug_ocimem_ram: single-port, byte-enable, 1-cycle registered-read RAM, depth 2**ADDR_W.

Test Plan:
- JTAG write then read: action_a (jdo[35]=1, addr 0x10), then action_b with data 0xDEADBEEF, then action_a addr 0x10 with jdo[34]=1 → MonDReg=0xDEADBEEF 2 cycles after the read strobe; jtag_busy falls the same cycle.
- Avalon write with debugaccess=1, addr 0x05, data 0x12345678, be=4'b0011, over prior 0xFFFFFFFF → Avalon read returns 0xFFFF5678; waitrequest low on cycle 4 of the read. Repeat with debugaccess=0 → RAM unchanged.
- Collision: Avalon read issued in the same cycle as a take_no_action_ocimem_a strobe → Avalon is served first (waitrequest low cycle 4), then MonDReg updates; both data values correct.
- Overrun: two strobes 1 cycle apart while the first is pending → status readback bit2=1; status write with writedata[1]=1 → bit2=0.
- With OCIMEM_AUTOINC_EN: load addr 0xFF (ADDR_W=8), two writes 0xA, 0xB → RAM[0xFF]=0xA, RAM[0x00]=0xB (wrap).
- Reset asserted during A_RD_W → waitrequest=1, MonDReg=0, jtag_busy=0 immediately; normal operation after release.
